ahblite_slave_ctrl: RTL and testbench
=====================================

AHBLITE_SLAVE_CTRL -- requirements
Module: ahblite_slave_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12: width of the register-space address passed to the backend.
REQ-002 Parameter WAIT_CYCLES, default 1, legal 0..15: data-phase wait states inserted per valid transfer.
REQ-003 HCLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 HRESETn  input  1  reset, asynchronous assert and active-low; deassertion is synchronous to HCLK.
REQ-005 HSEL  input  1  slave select.
REQ-006 HADDR  input  ADDR_W  address-phase address.
REQ-007 HTRANS  input  2  transfer type; bit 1 set = NONSEQ/SEQ.
REQ-008 HWRITE  input  1  1 = write.
REQ-009 HSIZE  input  3  transfer size.
REQ-010 HREADY  input  1  bus-level ready.
REQ-011 HWDATA  input  32  write data, valid in the data phase.
REQ-012 HRDATA  output  32  read data.
REQ-013 HREADYOUT  output  1  slave ready.
REQ-014 HRESP  output  1  0 = OKAY, 1 = ERROR.
REQ-015 reg_addr  output  ADDR_W  latched word address to the backend, with bits [1:0] forced to 0.
REQ-016 reg_be  output  4  latched byte enables.
REQ-017 reg_wr_en  output  1  one-cycle write strobe.
REQ-018 reg_rd_en  output  1  one-cycle read strobe.
REQ-019 reg_wdata  output  32  HWDATA passed through.
REQ-020 reg_rdata  input  32  backend read data, combinational and valid in the same cycle as reg_rd_en.

Function
REQ-021 The block SHALL accept an address phase only when HSEL=1, HTRANS[1]=1 and HREADY=1 at a rising edge. On acceptance it latches HADDR, HWRITE and HSIZE.
REQ-022 An accepted transfer SHALL be valid only when all of the following hold: HSIZE<=2, halfword has HADDR[0]=0, and word has HADDR[1:0]=0. All other accepted transfers SHALL be errors.
REQ-023 Byte-enable mapping:
  - byte: reg_be = 4'b0001 shifted left by HADDR[1:0].
  - halfword: 4'b0011 when HADDR[1]=0, 4'b1100 when HADDR[1]=1.
  - word: 4'b1111.
  - error transfers: 4'b0000.
REQ-024 The FSM SHALL have four states: IDLE, WAIT, ERR1, ERR2.
REQ-025 IDLE, valid transfer accepted:
  - with WAIT_CYCLES=0, stay IDLE; the next cycle is the final data-phase cycle.
  - otherwise go to WAIT and load the counter with WAIT_CYCLES.
REQ-026 WAIT: the counter decrements each cycle with HREADYOUT=0. When the counter reaches 0, the FSM returns to IDLE, and that next cycle is the final data-phase cycle.
REQ-027 Final data-phase cycle:
  - HREADYOUT=1 and HRESP=0.
  - exactly one of reg_wr_en or reg_rd_en is asserted for that single cycle, selected by the latched HWRITE.
  - for reads, HRDATA=reg_rdata.
REQ-028 Any state, error transfer accepted: go to ERR1.
  - ERR1: HREADYOUT=0, HRESP=1; unconditionally go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; then go to IDLE.
  - no backend strobe is issued for an error transfer.
REQ-029 Back-to-back: a new address phase accepted in the final data-phase cycle or in ERR2 SHALL be processed with no idle cycle.
REQ-030 IDLE/BUSY transfers, or HSEL=0 with HREADY=1, SHALL produce a zero-wait OKAY response and no strobe.
REQ-031 While HREADYOUT=0, no new address phase SHALL be sampled, because HREADY is low.
REQ-032 HRDATA SHALL be 32'h0 whenever no read strobe is active.
REQ-033 reg_wdata SHALL equal HWDATA combinationally.
REQ-034 Total data-phase latency for a valid transfer SHALL be WAIT_CYCLES+1 cycles. An error transfer SHALL take 2 cycles.

Reset
REQ-035 While HRESETn=0 the outputs and state SHALL be:
  - HREADYOUT=1, HRESP=0, reg_wr_en=0, reg_rd_en=0, HRDATA=0.
  - reg_addr=0, reg_be=0, counter=0, state=IDLE.
REQ-036 Reset asserted mid-transfer (in WAIT, ERR1 or ERR2) SHALL abort the transfer immediately with no strobe. After release the block waits for a new address phase.

Verification
REQ-037 WAIT_CYCLES=2, word write to 0x010 with HWDATA=0xDEADBEEF:
  - HREADYOUT low for 2 cycles, then high.
  - reg_wr_en high for 1 cycle with reg_addr=0x010, reg_be=4'b1111, reg_wdata=0xDEADBEEF.
REQ-038 WAIT_CYCLES=0, byte read at 0x013 with reg_rdata=0x11223344:
  - zero-wait OKAY response.
  - reg_be=4'b1000, reg_addr=0x010, reg_rd_en high for 1 cycle, HRDATA=0x11223344.
REQ-039 Error cases: halfword at 0x001, word at 0x002, HSIZE=3:
  - each gives the two-cycle ERROR response (HREADYOUT 0 then 1, HRESP=1 on both cycles).
  - no strobe, reg_be=4'b0000.
REQ-040 Back-to-back sequences, checked for no bubble between transfers and correct ordering of responses:
  - write 0x004 then read 0x008 with WAIT_CYCLES=1.
  - error then valid halfword write at 0x006, which must give reg_be=4'b1100.
REQ-041 HTRANS=IDLE, and HSEL=0, for 3 cycles each: HREADYOUT=1, HRESP=0, no strobes.
REQ-042 HRESETn asserted in the 2nd WAIT cycle (WAIT_CYCLES=3):
  - outputs immediately take reset values and no strobe ever occurs.
  - a subsequent word write completes normally.

Source files
------------

// File: rtl/ahblite_slave_ctrl.sv
// AHB-Lite slave front end: accepts address phases, inserts WAIT_CYCLES wait states,
// and issues single-cycle read/write strobes to a simple register backend.
module ahblite_slave_ctrl #(
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic              HREADY,
   input  logic [31:0]       HWDATA,
   output logic [31:0]       HRDATA,
   output logic              HREADYOUT,
   output logic              HRESP,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [3:0]        reg_be,
   output logic              reg_wr_en,
   output logic              reg_rd_en,
   output logic [31:0]       reg_wdata,
   input  logic [31:0]       reg_rdata
);

   typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic              write_q, write_d;
   logic              final_q, final_d;

   logic              accept;
   logic              valid;
   logic [3:0]        be_new;

   always_comb begin
      accept = HSEL && HTRANS[1] && HREADY;
      valid  = (HSIZE == 3'd0) ||
               ((HSIZE == 3'd1) && !HADDR[0]) ||
               ((HSIZE == 3'd2) && (HADDR[1:0] == 2'b00));
      case (HSIZE)
         3'd0:    be_new = 4'b0001 << HADDR[1:0];
         3'd1:    be_new = HADDR[1] ? 4'b1100 : 4'b0011;
         3'd2:    be_new = 4'b1111;
         default: be_new = 4'b0000;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      be_d      = be_q;
      write_d   = write_q;
      final_d   = 1'b0;
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;

      case (state_q)
         IDLE: begin
            HREADYOUT = 1'b1;
         end
         WAIT: begin
            HREADYOUT = 1'b0;
            cnt_d     = cnt_q - 4'd1;
            if (cnt_d == 4'd0) begin
               state_d = IDLE;
               final_d = 1'b1;
            end
         end
         ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
            state_d   = ERR2;
         end
         ERR2: begin
            HREADYOUT = 1'b1;
            HRESP     = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // New address phases are only taken while this slave drives HREADYOUT high.
      if (accept && (state_q == IDLE || state_q == ERR2)) begin
         addr_d  = {HADDR[ADDR_W-1:2], 2'b00};
         write_d = HWRITE;
         be_d    = valid ? be_new : 4'b0000;
         if (!valid) begin
            state_d = ERR1;
         end else if (WAIT_CYCLES == 0) begin
            state_d = IDLE;
            final_d = 1'b1;
         end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         be_q    <= 4'b0000;
         write_q <= 1'b0;
         final_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         write_q <= write_d;
         final_q <= final_d;
      end
   end

   assign reg_addr  = addr_q;
   assign reg_be    = be_q;
   assign reg_wr_en = final_q && write_q;
   assign reg_rd_en = final_q && !write_q;
   assign reg_wdata = HWDATA;
   assign HRDATA    = reg_rd_en ? reg_rdata : 32'h0;

endmodule

// File: tb/tb_ahblite_slave_ctrl.sv
// Directed bench: four controller instances (WAIT_CYCLES 0..3) share the bus signals,
// HSEL picks the target, and each instance's HREADY is its own HREADYOUT.
module tb_ahblite_slave_ctrl;

   localparam logic [1:0] NS = 2'b10;
   localparam logic [1:0] ID = 2'b00;
   localparam logic [3:0] OK_ = 4'b1000;  // {HREADYOUT, HRESP, wr, rd}
   localparam logic [3:0] WT  = 4'b0000;
   localparam logic [3:0] E1  = 4'b0100;
   localparam logic [3:0] E2  = 4'b1100;
   localparam logic [3:0] WR  = 4'b1010;
   localparam logic [3:0] RD  = 4'b1001;

   typedef struct {
      int          inst;
      logic        sel;
      logic [1:0]  tr;
      logic        wr;
      logic [2:0]  sz;
      logic [11:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      logic [3:0]  e;
      logic [31:0] ehr;
      logic        chk;
      logic [11:0] ea;
      logic [3:0]  ebe;
      string       nm;
   } vec_t;

   logic        clk = 1'b0;
   logic        hresetn;
   logic        sel_v;
   int          cur_inst;
   logic [11:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic [31:0] reg_rdata;

   logic [3:0]  hsel_w, hreadyout_w, hresp_w, wr_w, rd_w;
   logic [31:0] hrdata_w [4];
   logic [11:0] raddr_w  [4];
   logic [3:0]  be_w     [4];
   logic [31:0] wdata_w  [4];

   int checks = 0;
   int errors = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dut
         assign hsel_w[gi] = sel_v && (cur_inst == gi);
         ahblite_slave_ctrl #(.ADDR_W(12), .WAIT_CYCLES(gi)) u_dut (
            .HCLK      (clk),
            .HRESETn   (hresetn),
            .HSEL      (hsel_w[gi]),
            .HADDR     (haddr),
            .HTRANS    (htrans),
            .HWRITE    (hwrite),
            .HSIZE     (hsize),
            .HREADY    (hreadyout_w[gi]),
            .HWDATA    (hwdata),
            .HRDATA    (hrdata_w[gi]),
            .HREADYOUT (hreadyout_w[gi]),
            .HRESP     (hresp_w[gi]),
            .reg_addr  (raddr_w[gi]),
            .reg_be    (be_w[gi]),
            .reg_wr_en (wr_w[gi]),
            .reg_rd_en (rd_w[gi]),
            .reg_wdata (wdata_w[gi]),
            .reg_rdata (reg_rdata)
         );
      end
   endgenerate

   function automatic vec_t V(input int inst, input logic sel, input logic [1:0] tr,
                              input logic wr, input logic [2:0] sz, input logic [11:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic [3:0] e,
                              input logic [31:0] ehr, input logic chk, input logic [11:0] ea,
                              input logic [3:0] ebe, input string nm);
      vec_t v;
      v.inst = inst; v.sel = sel; v.tr = tr; v.wr = wr; v.sz = sz; v.a = a;
      v.wd = wd; v.rd = rd; v.e = e; v.ehr = ehr; v.chk = chk; v.ea = ea; v.ebe = ebe;
      v.nm = nm;
      return v;
   endfunction

   task automatic check(input int i, input logic [3:0] e, input logic [31:0] ehr,
                        input logic chk, input logic [11:0] ea, input logic [3:0] ebe,
                        input logic [31:0] ewd, input string nm);
      logic [3:0] g;
      g = {hreadyout_w[i], hresp_w[i], wr_w[i], rd_w[i]};
      checks++;
      if (g !== e || hrdata_w[i] !== ehr) begin
         errors++;
         $display("FAIL %s inst%0d rdy/resp/wr/rd=%b hrdata=%h, required %b %h",
                  nm, i, g, hrdata_w[i], e, ehr);
      end
      if (chk) begin
         checks++;
         if (raddr_w[i] !== ea || be_w[i] !== ebe) begin
            errors++;
            $display("FAIL %s_ab inst%0d reg_addr=%h reg_be=%b, required %h %b",
                     nm, i, raddr_w[i], be_w[i], ea, ebe);
         end
      end
      if (e[1]) begin
         checks++;
         if (wdata_w[i] !== ewd) begin
            errors++;
            $display("FAIL %s_wdata inst%0d reg_wdata=%h, required %h", nm, i, wdata_w[i], ewd);
         end
      end
      if (chk) $display("txn %s inst%0d flags=%b addr=%h be=%b", nm, i, g, raddr_w[i], be_w[i]);
   endtask

   task automatic step(input vec_t v);
      @(negedge clk);
      cur_inst  = v.inst;
      sel_v     = v.sel;
      htrans    = v.tr;
      hwrite    = v.wr;
      hsize     = v.sz;
      haddr     = v.a;
      hwdata    = v.wd;
      reg_rdata = v.rd;
      #1;
      check(v.inst, v.e, v.ehr, v.chk, v.ea, v.ebe, v.wd, v.nm);
   endtask

   initial begin
      // word write, 2 wait states
      tbl.push_back(V(2,1,NS,1,2,'h010,0,0,OK_,0,0,0,0,"w_addr"));
      tbl.push_back(V(2,1,ID,0,0,0,'hDEADBEEF,0,WT,0,0,0,0,"w_wait1"));
      tbl.push_back(V(2,1,ID,0,0,0,'hDEADBEEF,0,WT,0,0,0,0,"w_wait2"));
      tbl.push_back(V(2,1,ID,0,0,0,'hDEADBEEF,0,WR,0,1,'h010,'hF,"w_final"));
      tbl.push_back(V(2,1,ID,0,0,0,0,0,OK_,0,0,0,0,"w_after"));
      // zero-wait byte read
      tbl.push_back(V(0,1,NS,0,0,'h013,0,'h11223344,OK_,0,0,0,0,"rb_addr"));
      tbl.push_back(V(0,1,ID,0,0,0,0,'h11223344,RD,'h11223344,1,'h010,'h8,"rb_final"));
      tbl.push_back(V(0,1,ID,0,0,0,0,'h11223344,OK_,0,0,0,0,"rb_hrdata_zero"));
      // zero-wait back-to-back writes
      tbl.push_back(V(0,1,NS,1,0,'h001,0,0,OK_,0,0,0,0,"b2b0_addr"));
      tbl.push_back(V(0,1,NS,1,1,'h002,'h000000AA,0,WR,0,1,'h000,'h2,"b2b0_byte"));
      tbl.push_back(V(0,1,ID,0,0,0,'hBBBB0000,0,WR,0,1,'h000,'hC,"b2b0_half"));
      tbl.push_back(V(0,1,ID,0,0,0,0,0,OK_,0,0,0,0,"b2b0_idle"));
      // error chain: misaligned halfword, misaligned word, HSIZE=3
      tbl.push_back(V(1,1,NS,1,1,'h001,0,0,OK_,0,0,0,0,"e_half_addr"));
      tbl.push_back(V(1,1,ID,0,0,0,0,0,E1,0,1,'h000,0,"e_half_err1"));
      tbl.push_back(V(1,1,NS,0,2,'h002,0,'h55,E2,0,1,'h000,0,"e_half_err2"));
      tbl.push_back(V(1,1,ID,0,0,0,0,'h55,E1,0,1,'h000,0,"e_word_err1"));
      tbl.push_back(V(1,1,NS,1,3,'h008,0,0,E2,0,1,'h000,0,"e_word_err2"));
      tbl.push_back(V(1,1,ID,0,0,0,0,0,E1,0,1,'h008,0,"e_sz3_err1"));
      tbl.push_back(V(1,1,ID,0,0,0,0,0,E2,0,1,'h008,0,"e_sz3_err2"));
      tbl.push_back(V(1,1,ID,0,0,0,0,0,OK_,0,0,0,0,"e_idle"));
      // 1-wait write then read, read address held through the wait state
      tbl.push_back(V(1,1,NS,1,2,'h004,0,0,OK_,0,0,0,0,"bb_w_addr"));
      tbl.push_back(V(1,1,NS,0,2,'h008,'hA5A50004,0,WT,0,0,0,0,"bb_w_wait"));
      tbl.push_back(V(1,1,NS,0,2,'h008,'hA5A50004,0,WR,0,1,'h004,'hF,"bb_w_final"));
      tbl.push_back(V(1,1,ID,0,0,0,0,'h0BADF00D,WT,0,0,0,0,"bb_r_wait"));
      tbl.push_back(V(1,1,ID,0,0,0,0,'h0BADF00D,RD,'h0BADF00D,1,'h008,'hF,"bb_r_final"));
      tbl.push_back(V(1,1,ID,0,0,0,0,0,OK_,0,0,0,0,"bb_idle"));
      // error then valid halfword write at 0x006
      tbl.push_back(V(1,1,NS,1,1,'h003,0,0,OK_,0,0,0,0,"eh_addr"));
      tbl.push_back(V(1,1,ID,0,0,0,0,0,E1,0,1,'h000,0,"eh_err1"));
      tbl.push_back(V(1,1,NS,1,1,'h006,0,0,E2,0,1,'h000,0,"eh_err2"));
      tbl.push_back(V(1,1,ID,0,0,0,'h12345678,0,WT,0,0,0,0,"eh_wait"));
      tbl.push_back(V(1,1,ID,0,0,0,'h12345678,0,WR,0,1,'h004,'hC,"eh_final"));
      tbl.push_back(V(1,1,ID,0,0,0,0,0,OK_,0,0,0,0,"eh_idle"));
      // IDLE/BUSY transfers and deselected slave
      for (int k = 0; k < 3; k++)
         tbl.push_back(V(0,1,ID,1,2,'h000,0,'hFFFFFFFF,OK_,0,0,0,0,"idle_trans"));
      tbl.push_back(V(0,1,2'b01,1,2,'h000,0,'hFFFFFFFF,OK_,0,0,0,0,"busy_trans"));
      for (int k = 0; k < 3; k++)
         tbl.push_back(V(0,0,NS,0,2,'h010,0,'hFFFFFFFF,OK_,0,0,0,0,"hsel0"));
      tbl.push_back(V(0,0,ID,0,0,0,0,'hFFFFFFFF,OK_,0,0,0,0,"hsel0_after"));

      hresetn = 1'b0; sel_v = 1'b1; cur_inst = 2; htrans = NS; hwrite = 1'b1;
      hsize = 3'd2; haddr = 12'h010; hwdata = 32'h0; reg_rdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      for (int i = 0; i < 4; i++) check(i, OK_, 32'h0, 1'b1, 12'h000, 4'h0, 32'h0, "reset");
      @(negedge clk);
      sel_v = 1'b0; htrans = ID;
      hresetn = 1'b1;

      for (int k = 0; k < tbl.size(); k++) step(tbl[k]);

      // reset in the 2nd wait cycle of a WAIT_CYCLES=3 write
      step(V(3,1,NS,1,2,'h020,'hCAFE0000,0,OK_,0,0,0,0,"rst_addr"));
      step(V(3,1,ID,0,0,0,'hCAFE0000,0,WT,0,0,0,0,"rst_wait1"));
      step(V(3,1,ID,0,0,0,'hCAFE0000,0,WT,0,1,'h020,'hF,"rst_wait2"));
      #2 hresetn = 1'b0;
      #1 check(3, OK_, 32'h0, 1'b1, 12'h000, 4'h0, 32'h0, "rst_async");
      repeat (2) begin
         @(negedge clk); #1;
         check(3, OK_, 32'h0, 1'b1, 12'h000, 4'h0, 32'h0, "rst_hold");
      end
      @(negedge clk);
      hresetn = 1'b1;
      for (int k = 0; k < 4; k++)
         step(V(3,1,ID,0,0,0,'hCAFE0000,0,OK_,0,1,'h000,'h0,"rst_post"));
      step(V(3,1,NS,1,2,'h030,0,0,OK_,0,0,0,0,"pr_addr"));
      for (int k = 0; k < 3; k++)
         step(V(3,1,ID,0,0,0,'h600DF00D,0,WT,0,0,0,0,"pr_wait"));
      step(V(3,1,ID,0,0,0,'h600DF00D,0,WR,0,1,'h030,'hF,"pr_final"));
      step(V(3,1,ID,0,0,0,0,0,OK_,0,0,0,0,"pr_idle"));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
